s2_regread_stage: RTL and testbench
===================================

Name: s2_regread_stage

Overview:
- Stage 2 of the lab pipeline. It sits directly downstream of the stage-1 decode register and consumes its read selects, write select and write enable.
- It holds a 32-entry register file. Each cycle it reads two operands and captures them, together with the forwarded write select and enable, into the stage-2 pipeline register.
- A writeback port from the final stage updates the register file.
- Stall and flush controls hold or bubble the stage.

Parameters:
- DATA_WIDTH, 32, width of each register-file entry and of the read and write data paths.
- NUM_REGS, 32, number of register-file entries. Fixed at 32 to match the 5-bit selects; any other value is unsupported.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- S1_ReadSelect1  input  5  operand-1 register index from stage 1
- S1_ReadSelect2  input  5  operand-2 register index from stage 1
- S1_WriteSelect  input  5  destination index from stage 1
- S1_WriteEnable  input  1  destination valid from stage 1
- stall  input  1  hold stage-2 register contents
- flush  input  1  insert bubble into stage-2 register
- WB_WriteSelect  input  5  writeback destination index
- WB_WriteData  input  DATA_WIDTH  writeback data
- WB_WriteEnable  input  1  writeback strobe
- S2_ReadData1  output  DATA_WIDTH  registered operand 1
- S2_ReadData2  output  DATA_WIDTH  registered operand 2
- S2_WriteSelect  output  5  registered destination index
- S2_WriteEnable  output  1  registered destination valid

Behaviour:
- Reset (rst=1 at posedge):
  - All NUM_REGS entries cleared to 0.
  - S2_ReadData1/2 = 0, S2_WriteSelect = 0, S2_WriteEnable = 0.
  - Writeback is ignored in that cycle.
  - A reset asserted mid-operation discards in-flight state with no partial update.
- Register file:
  - Combinational read of entries S1_ReadSelect1 and S1_ReadSelect2.
  - Synchronous write at posedge when WB_WriteEnable=1 and rst=0: entry[WB_WriteSelect] <= WB_WriteData.
  - Entry 0 is hardwired to zero. Writes to index 0 are dropped and reads of index 0 return 0, including under bypass.
- Stage-2 register priority (highest first): rst, flush, stall, normal.
  - flush=1: S2_ReadData1/2 <= 0, S2_WriteSelect <= 0, S2_WriteEnable <= 0. Flush wins over stall.
  - stall=1 (flush=0): all S2 outputs hold their previous values.
  - Normal: S2_ReadData1/2 <= operand values; S2_WriteSelect <= S1_WriteSelect; S2_WriteEnable <= S1_WriteEnable.
- Writeback is independent of stall and flush: the register-file write occurs whenever WB_WriteEnable=1 and rst=0.
- Latency:
  - Stage-1 outputs present before posedge N appear on the S2 outputs after posedge N (1 cycle).
  - A writeback at posedge N is visible to a read captured at posedge N+1 or later.
- Same-cycle conflict (WB index equals a read select, nonzero, WB_WriteEnable=1): the captured value is governed by the optional feature below.
- Both read selects equal: both outputs carry the same value.
- Index arithmetic: 5-bit indices use no wrap or offset; all 32 indices are valid.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: on a same-cycle conflict, the operand captured into S2 is WB_WriteData (write-before-read forwarding), applied independently per read port; the index-0 rule still applies.
- Undefined: on a same-cycle conflict, S2 captures the old register-file contents; the new value is visible from the next capture.
- Register-file update timing is identical in both builds.

Test Plan:
- Reset: assert rst 2 cycles with WB_WriteEnable=1, WB_WriteSelect=5, WB_WriteData=0xDEADBEEF -> all S2 outputs 0; later read of r5 returns 0.
- Write then read: WB write r3=0x12345678 at posedge N; at N+1 drive ReadSelect1=3, ReadSelect2=0, WriteSelect=7, WriteEnable=1 -> after N+2: ReadData1=0x12345678, ReadData2=0, WriteSelect=7, WriteEnable=1.
- r0 immunity: WB write r0=0xFFFFFFFF, then read r0 on both ports -> both 0, in both builds.
- Same-cycle conflict: r4 holds 0x11; in one cycle WB writes r4=0x22 and ReadSelect1=4 -> ReadData1=0x22 with RF_BYPASS_EN, 0x11 without; next capture of r4 gives 0x22 in both builds.
- Stall: capture r3 (0x12345678), then stall 3 cycles while selects change and WB writes r3=0x99 -> outputs hold 0x12345678; first capture after release reads 0x99.
- Flush over stall: flush=1, stall=1 with S1_WriteEnable=1, WriteSelect=9 -> S2_WriteEnable=0, WriteSelect=0, data 0; a WB write of r9 in the same cycle still lands.

Source files
------------

// File: rtl/s2_regread_if.sv
// Stage-2 register-read bundle: stage-1 selects, stall/flush, writeback port and
// the registered stage-2 outputs. The slave modport is the stage and the master modport drives it.
interface s2_regread_if #(
  parameter int DATA_WIDTH = 32
);
  logic [4:0]            S1_ReadSelect1;
  logic [4:0]            S1_ReadSelect2;
  logic [4:0]            S1_WriteSelect;
  logic                  S1_WriteEnable;
  logic                  stall;
  logic                  flush;
  logic [4:0]            WB_WriteSelect;
  logic [DATA_WIDTH-1:0] WB_WriteData;
  logic                  WB_WriteEnable;
  logic [DATA_WIDTH-1:0] S2_ReadData1;
  logic [DATA_WIDTH-1:0] S2_ReadData2;
  logic [4:0]            S2_WriteSelect;
  logic                  S2_WriteEnable;

  modport master (
    output S1_ReadSelect1, S1_ReadSelect2, S1_WriteSelect, S1_WriteEnable,
    output stall, flush, WB_WriteSelect, WB_WriteData, WB_WriteEnable,
    input  S2_ReadData1, S2_ReadData2, S2_WriteSelect, S2_WriteEnable
  );

  modport slave (
    input  S1_ReadSelect1, S1_ReadSelect2, S1_WriteSelect, S1_WriteEnable,
    input  stall, flush, WB_WriteSelect, WB_WriteData, WB_WriteEnable,
    output S2_ReadData1, S2_ReadData2, S2_WriteSelect, S2_WriteEnable
  );
endinterface

// File: rtl/s2_regread_stage.sv
// Pipeline stage 2: 32-entry register file (r0 hardwired to zero) feeding the stage-2 register.
// Define RF_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module s2_regread_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic          clk,
  input  logic          rst,
  s2_regread_if.slave   bus
);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];

  // Writeback proceeds regardless of stall/flush; only reset suppresses it.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_d[i] = rf_q[i];
      if (rst) begin
        rf_d[i] = '0;
      end else if (bus.WB_WriteEnable && (bus.WB_WriteSelect == 5'(i))) begin
        rf_d[i] = bus.WB_WriteData;
      end
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_q[i] <= rf_d[i];
    end
  end

  logic [4:0]            rd_sel [2];
  logic [DATA_WIDTH-1:0] rd_val [2];

  assign rd_sel[0] = bus.S1_ReadSelect1;
  assign rd_sel[1] = bus.S1_ReadSelect2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef RF_BYPASS_EN
      logic rd_hit;
      assign rd_hit = bus.WB_WriteEnable && (bus.WB_WriteSelect == rd_sel[gi]);
      assign rd_val[gi] = (rd_sel[gi] == 5'd0) ? '0 :
                          rd_hit               ? bus.WB_WriteData :
                                                 rf_q[rd_sel[gi]];
`else
      assign rd_val[gi] = (rd_sel[gi] == 5'd0) ? '0 : rf_q[rd_sel[gi]];
`endif
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
  logic [4:0]            ws_q, ws_d;
  logic                  we_q, we_d;

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    ws_d  = ws_q;
    we_d  = we_q;
    if (rst || bus.flush) begin
      rd1_d = '0;
      rd2_d = '0;
      ws_d  = '0;
      we_d  = 1'b0;
    end else if (!bus.stall) begin
      rd1_d = rd_val[0];
      rd2_d = rd_val[1];
      ws_d  = bus.S1_WriteSelect;
      we_d  = bus.S1_WriteEnable;
    end
  end

  always_ff @(posedge clk) begin
    rd1_q <= rd1_d;
    rd2_q <= rd2_d;
    ws_q  <= ws_d;
    we_q  <= we_d;
  end

  assign bus.S2_ReadData1   = rd1_q;
  assign bus.S2_ReadData2   = rd2_q;
  assign bus.S2_WriteSelect = ws_q;
  assign bus.S2_WriteEnable = we_q;

endmodule

// File: tb/tb_s2_regread_stage.sv
// Self-checking bench for s2_regread_stage: a vector table plus a register sweep,
// with expected outputs queued at drive time and compared one cycle later.
module tb_s2_regread_stage;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  s2_regread_if #(.DATA_WIDTH(32)) bus ();

  s2_regread_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush;
    logic [4:0]  rs1, rs2, ws;
    logic        we;
    logic [4:0]  wbs;
    logic [31:0] wbd;
    logic        wbe;
    logic [31:0] e1, e2;
    logic [4:0]  ews;
    logic        ewe;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] e1, e2;
    logic [4:0]  ews;
    logic        ewe;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int txn    = 0;

  function automatic vec_t v(input logic r, input logic st, input logic fl,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] ws, input logic we,
                             input logic [4:0] wbs, input logic [31:0] wbd, input logic wbe,
                             input logic [31:0] e1, input logic [31:0] e2,
                             input logic [4:0] ews, input logic ewe);
    vec_t t;
    t.rst = r; t.stall = st; t.flush = fl;
    t.rs1 = rs1; t.rs2 = rs2; t.ws = ws; t.we = we;
    t.wbs = wbs; t.wbd = wbd; t.wbe = wbe;
    t.e1 = e1; t.e2 = e2; t.ews = ews; t.ewe = ewe;
    return t;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t t);
    exp_t e, p;
    rst                = t.rst;
    bus.stall          = t.stall;
    bus.flush          = t.flush;
    bus.S1_ReadSelect1 = t.rs1;
    bus.S1_ReadSelect2 = t.rs2;
    bus.S1_WriteSelect = t.ws;
    bus.S1_WriteEnable = t.we;
    bus.WB_WriteSelect = t.wbs;
    bus.WB_WriteData   = t.wbd;
    bus.WB_WriteEnable = t.wbe;
    e.id = txn; e.e1 = t.e1; e.e2 = t.e2; e.ews = t.ews; e.ewe = t.ewe;
    sb.push_back(e);
    @(posedge clk);
    #1;
    p = sb.pop_front();
    chk("rd1", p.id, bus.S2_ReadData1, p.e1);
    chk("rd2", p.id, bus.S2_ReadData2, p.e2);
    chk("ws",  p.id, 32'(bus.S2_WriteSelect), 32'(p.ews));
    chk("we",  p.id, 32'(bus.S2_WriteEnable), 32'(p.ewe));
    $display("txn %0d rst=%0b st=%0b fl=%0b rs=%0d/%0d wb=%0b r%0d=0x%08h -> d1=0x%08h d2=0x%08h ws=%0d we=%0b",
             p.id, t.rst, t.stall, t.flush, t.rs1, t.rs2, t.wbe, t.wbs, t.wbd,
             bus.S2_ReadData1, bus.S2_ReadData2, bus.S2_WriteSelect, bus.S2_WriteEnable);
    txn++;
  endtask

  logic [31:0] model [32];

  initial begin
    //                rst st fl rs1 rs2 ws we wbs wbd           wbe  e1                        e2            ews ewe
    vecs.push_back(v(1, 0, 0, 0,  0,  3, 1, 5,  32'hDEADBEEF, 1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(1, 0, 0, 5,  5,  3, 1, 5,  32'hDEADBEEF, 1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 5,  5,  0, 0, 0,  32'h0,        0,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 0,  0,  0, 0, 3,  32'h12345678, 1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 3,  0,  7, 1, 0,  32'h0,        0,  32'h12345678,             32'h0,        7,  1));
    vecs.push_back(v(0, 0, 0, 0,  0,  0, 0, 0,  32'hFFFFFFFF, 1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 0,  0,  0, 0, 0,  32'h0,        0,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 0,  0,  0, 0, 4,  32'h11,       1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 4,  3,  0, 0, 4,  32'h22,       1,  BYP ? 32'h22 : 32'h11,    32'h12345678, 0,  0));
    vecs.push_back(v(0, 0, 0, 4,  4,  0, 0, 0,  32'h0,        0,  32'h22,                   32'h22,       0,  0));
    vecs.push_back(v(0, 0, 0, 3,  4,  2, 1, 0,  32'h0,        0,  32'h12345678,             32'h22,       2,  1));
    vecs.push_back(v(0, 1, 0, 9,  9,  5, 0, 3,  32'h99,       1,  32'h12345678,             32'h22,       2,  1));
    vecs.push_back(v(0, 1, 0, 1,  3,  6, 0, 0,  32'h0,        0,  32'h12345678,             32'h22,       2,  1));
    vecs.push_back(v(0, 1, 0, 3,  3,  6, 0, 0,  32'h0,        0,  32'h12345678,             32'h22,       2,  1));
    vecs.push_back(v(0, 0, 0, 3,  3,  1, 0, 0,  32'h0,        0,  32'h99,                   32'h99,       1,  0));
    vecs.push_back(v(0, 1, 1, 3,  3,  9, 1, 9,  32'hABCD,     1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 9,  3,  9, 1, 0,  32'h0,        0,  32'hABCD,                 32'h99,       9,  1));
    vecs.push_back(v(0, 0, 0, 6,  3,  0, 0, 6,  32'h66,       1,  BYP ? 32'h66 : 32'h0,     32'h99,       0,  0));
    vecs.push_back(v(1, 0, 0, 0,  6,  4, 1, 6,  32'h77,       1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 6,  3,  0, 0, 0,  32'h0,        0,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 1, 3,  3,  8, 1, 10, 32'h5,        1,  32'h0,                    32'h0,        0,  0));
    vecs.push_back(v(0, 0, 0, 10, 10, 31, 1, 0, 32'h0,        0,  32'h5,                    32'h5,        31, 1));
    vecs.push_back(v(0, 0, 0, 31, 31, 0, 0, 31, 32'h1F1F,     1,  BYP ? 32'h1F1F : 32'h0,   BYP ? 32'h1F1F : 32'h0, 0, 0));
    vecs.push_back(v(0, 0, 0, 31, 0,  0, 0, 0,  32'h0,        0,  32'h1F1F,                 32'h0,        0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Sweep: reset, write every index (r0 must drop), then read pairs back.
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0));
    for (int i = 0; i < 32; i++) begin
      model[i] = (i == 0) ? 32'h0 : (32'hA5000000 | (i * 32'h00010203));
      apply(v(0, 0, 0, 0, 0, 0, 0, 5'(i), 32'hA5000000 | (i * 32'h00010203), 1,
              32'h0, 32'h0, 0, 0));
    end
    for (int i = 0; i < 32; i++) begin
      apply(v(0, 0, 0, 5'(i), 5'(31 - i), 5'(i), i[0], 0, 32'h0, 0,
              model[i], model[31 - i], 5'(i), i[0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
